err_acc_sequencer: RTL and testbench
====================================

# err_acc_sequencer

Initiator-side sequencer for the output-layer error accumulator. It accepts a burst of NUM_ERR floating-point error scalars over a valid/ready stream and drives the accumulator's INPUT_SCALER and ACC_EN so that the first scalar discards any stale sum, later scalars accumulate, and stall cycles add zero. After the burst it captures ACC_RESULT and presents the total on a valid/ready output toward the backpropagation control.

## Interface

- BIT_WIDTH, 32, floating-point size in bits.
- EXTRA_BITS, 2, flopoco exception bits on the float. Legal values are only 0 and 2.
- COUNT_WIDTH, 8, width of the burst-length counter.

Ports:

- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request that begins a burst. Sampled only in IDLE.
- NUM_ERR  in  COUNT_WIDTH  number of scalars in the burst. Latched on START.
- ERR_IN  in  BIT_WIDTH+EXTRA_BITS  incoming error scalar.
- ERR_VALID  in  1  ERR_IN is valid.
- ERR_READY  out  1  block accepts ERR_IN.
- ACC_INPUT  out  BIT_WIDTH+EXTRA_BITS  drives the accumulator's INPUT_SCALER.
- ACC_EN  out  1  drives the accumulator's ACC_EN. When 0, the accumulator's next value is ACC_INPUT alone.
- ACC_RESULT  in  BIT_WIDTH+EXTRA_BITS  registered sum from the accumulator.
- SUM_OUT  out  BIT_WIDTH+EXTRA_BITS  captured total, registered.
- SUM_VALID  out  1  SUM_OUT is valid.
- SUM_READY  in  1  downstream consumes SUM_OUT.
- BUSY  out  1  high in any state except IDLE.

## Operation

- Accumulator contract: each CLK edge the accumulator loads ACC_INPUT + (ACC_EN ? ACC_RESULT : 0). Its own RESET input is tied low.
- ZERO is all bits 0. It is float zero in both the EXTRA_BITS=0 and EXTRA_BITS=2 encodings.
- Registers:
  - state: IDLE, FEED, WAIT or OUT.
  - target: NUM_ERR latched on START.
  - cnt: number of scalars accepted so far, COUNT_WIDTH bits.
  - SUM_OUT.
- Accept condition: accept = (state==FEED) & ERR_VALID. ERR_READY = (state==FEED).
- ACC_INPUT is combinational: accept ? ERR_IN : ZERO.
- ACC_EN is combinational: (state==FEED or state==WAIT) & (cnt != 0). As a result:
  - the first accepted scalar overwrites the stale sum;
  - stall cycles add ZERO to the running sum;
  - IDLE and OUT flush the accumulator toward zero.
- Transitions:
  - IDLE -> FEED on START when NUM_ERR != 0. On entry: target <= NUM_ERR, cnt <= 0.
  - IDLE -> WAIT on START when NUM_ERR == 0. The accumulator already holds ZERO, so SUM_OUT becomes zero.
  - FEED: on each accept, cnt <= cnt+1. When accept occurs with cnt == target-1, go to WAIT.
  - WAIT lasts exactly one cycle. At its closing edge: SUM_OUT <= ACC_RESULT, then go to OUT.
  - OUT: SUM_VALID=1. When SUM_READY=1, go to IDLE. SUM_OUT holds its value until the next capture.
- START outside IDLE is ignored. NUM_ERR changes outside the START cycle are ignored.
- cnt never wraps: the maximum target is 2^COUNT_WIDTH-1, so cnt tops out at target-1 before leaving FEED.
- No arithmetic is done inside the block. Values pass through bit-exact.

## Timing

- Reset values: ERR_READY=0, ACC_INPUT=ZERO, ACC_EN=0, SUM_OUT=0, SUM_VALID=0, BUSY=0, state=IDLE, cnt=0, target=0.
- RESET_N low at any time, including mid-burst or while SUM_VALID=1, returns the block to the reset values immediately. Any partial burst is discarded.
- Edge with START in IDLE -> FEED is active from the next cycle. ERR_READY is high in the first FEED cycle.
- One scalar per cycle at best. The burst takes NUM_ERR cycles with ERR_VALID held high.
- SUM_VALID rises 2 edges after the edge that accepts the last scalar: one edge to WAIT, one to capture.
- SUM_VALID rises 2 edges after START when NUM_ERR == 0.
- SUM_READY asserted in the first OUT cycle gives a one-cycle SUM_VALID pulse. The block is back in IDLE the next cycle.
- Back-to-back bursts: the earliest accepted START is the first IDLE cycle after OUT.

## Test plan

Floats below use EXTRA_BITS=2: 1.0 = 34'h1_3F80_0000, 2.0 = 34'h1_4000_0000, 3.0 = 34'h1_4040_0000, 6.0 = 34'h1_40C0_0000. The bench includes the real accumulator.

- START with NUM_ERR=3; feed 1.0, 2.0, 3.0 on consecutive cycles -> SUM_OUT = 34'h1_40C0_0000. SUM_VALID rises 2 edges after the 3rd accept. ACC_EN is 0,1,1 on the accept cycles.
- Same burst with ERR_VALID low for 4 cycles between 2.0 and 3.0 -> ACC_INPUT = ZERO and ACC_EN = 1 during the gap; SUM_OUT is still 6.0.
- Two bursts back to back: {3.0} then {1.0}, both with NUM_ERR=1 -> second SUM_OUT = 34'h1_3F80_0000, showing no carry-over from the first burst.
- START with NUM_ERR=0 -> SUM_OUT = 0 and SUM_VALID high 2 edges after START. ERR_READY is never asserted.
- Hold SUM_READY=0 for 5 cycles in OUT, and pulse START during that time -> SUM_VALID and SUM_OUT are held and the START is ignored. SUM_READY=1 returns the block to IDLE the next cycle.
- Drop RESET_N low after the 2nd accept of a 3-scalar burst -> all outputs go to reset values asynchronously. A new burst {2.0} then gives SUM_OUT = 34'h1_4000_0000.

Source files
------------

// File: rtl/err_acc_sequencer_if.sv
// err_acc_sequencer_if: error stream, accumulator drive and sum output bundle for err_acc_sequencer
//   slave modport is the sequencer side; master modport is the surrounding system
//   start/num_err: burst request; err_*: error scalar stream; acc_*: accumulator drive/result; sum_*: total out; busy: not idle
interface err_acc_sequencer_if #(
  parameter int W = 34,
  parameter int CW = 8
);
  logic start;
  logic [CW-1:0] num_err;
  logic [W-1:0] err_in;
  logic err_valid;
  logic err_ready;
  logic [W-1:0] acc_input;
  logic acc_en;
  logic [W-1:0] acc_result;
  logic [W-1:0] sum_out;
  logic sum_valid;
  logic sum_ready;
  logic busy;
  modport slave (
    input start, num_err, err_in, err_valid, acc_result, sum_ready,
    output err_ready, acc_input, acc_en, sum_out, sum_valid, busy
  );
  modport master (
    output start, num_err, err_in, err_valid, acc_result, sum_ready,
    input err_ready, acc_input, acc_en, sum_out, sum_valid, busy
  );
endinterface

// File: rtl/err_acc_sequencer.sv
// err_acc_sequencer: feeds a burst of error scalars into an external accumulator and returns the captured total
//   clk, reset_n (async active-low); bus: err_acc_sequencer_if.slave carrying the error stream,
//   accumulator drive (acc_input/acc_en/acc_result) and the sum_out/sum_valid/sum_ready output
module err_acc_sequencer #(
  parameter int BIT_WIDTH = 32,
  parameter int EXTRA_BITS = 2,
  parameter int COUNT_WIDTH = 8
) (
  input logic clk,
  input logic reset_n,
  err_acc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FEED, WAIT, OUT} state_t;
  state_t state, state_nx;
  logic [COUNT_WIDTH-1:0] cnt, target;
  logic [BIT_WIDTH+EXTRA_BITS-1:0] sum_q;
  logic accept, last;
  assign accept = state == FEED && bus.err_valid;
  assign last = cnt == target - COUNT_WIDTH'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? (bus.num_err != '0 ? FEED : WAIT) : IDLE;
      FEED: state_nx = accept && last ? WAIT : FEED;
      WAIT: state_nx = OUT;
      default: state_nx = bus.sum_ready ? IDLE : OUT;
    endcase
  end
  // cnt==0 keeps acc_en low so the first scalar overwrites the stale sum; idle/out flush toward zero
  assign bus.err_ready = state == FEED;
  assign bus.acc_input = accept ? bus.err_in : '0;
  assign bus.acc_en = (state == FEED || state == WAIT) && cnt != '0;
  assign bus.sum_out = sum_q;
  assign bus.sum_valid = state == OUT;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      target <= '0;
      sum_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        target <= bus.num_err;
        cnt <= '0;
      end else if (accept) cnt <= cnt + COUNT_WIDTH'(1);
      if (state == WAIT) sum_q <= bus.acc_result;
    end
  end
endmodule

// File: tb/tb_err_acc_sequencer.sv
// tb_err_acc_sequencer: directed and randomized bench for err_acc_sequencer with a float accumulator model
module tb_err_acc_sequencer;
  localparam int W = 34;
  localparam int CW = 8;
  localparam logic [W-1:0] F1 = 34'h1_3F80_0000;
  localparam logic [W-1:0] F2 = 34'h1_4000_0000;
  localparam logic [W-1:0] F3 = 34'h1_4040_0000;
  localparam logic [W-1:0] F6 = 34'h1_40C0_0000;
  logic clk = 0;
  logic reset_n = 0;
  logic [W-1:0] acc = '0;
  int vecs = 0;
  int errs = 0;
  err_acc_sequencer_if #(.W(W), .CW(CW)) bus ();
  err_acc_sequencer #(.BIT_WIDTH(32), .EXTRA_BITS(2), .COUNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // positive-only flopoco float add, exact for the small integer values used here
  function automatic logic [W-1:0] fadd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] x, y;
    logic [7:0] d;
    logic [23:0] mb;
    logic [24:0] s;
    if (a[33:32] == 2'b00) return b;
    if (b[33:32] == 2'b00) return a;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end else begin x = b; y = a; end
    d = x[30:23] - y[30:23];
    mb = d > 8'd23 ? 24'd0 : {1'b1, y[22:0]} >> d;
    s = {2'b01, x[22:0]} + {1'b0, mb};
    return s[24] ? {2'b01, 1'b0, x[30:23] + 8'd1, s[23:1]} : {2'b01, 1'b0, x[30:23], s[22:0]};
  endfunction
  function automatic logic [W-1:0] int2f(int n);
    int p;
    logic [31:0] u;
    if (n == 0) return '0;
    p = 0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    u = 32'(n) << (23 - p);
    return {2'b01, 1'b0, 8'(127 + p), u[22:0]};
  endfunction
  assign bus.acc_result = acc;
  always @(posedge clk) acc <= fadd(bus.acc_input, bus.acc_en ? acc : '0);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset_n = 0;
    bus.start = 1; bus.num_err = 3; bus.err_valid = 1; bus.err_in = F3; bus.sum_ready = 0;
    tick; tick;
    vecs++; if (bus.err_ready !== 1'b0) begin errs++; $display("FAIL rst_err_ready got %h exp 0", bus.err_ready); end
    vecs++; if (bus.acc_input !== '0) begin errs++; $display("FAIL rst_acc_input got %h exp 0", bus.acc_input); end
    vecs++; if (bus.acc_en !== 1'b0) begin errs++; $display("FAIL rst_acc_en got %h exp 0", bus.acc_en); end
    vecs++; if (bus.sum_out !== '0) begin errs++; $display("FAIL rst_sum_out got %h exp 0", bus.sum_out); end
    vecs++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL rst_sum_valid got %h exp 0", bus.sum_valid); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %h exp 0", bus.busy); end
    bus.start = 0; bus.err_valid = 0;
    reset_n = 1;
    tick; tick;
  endtask
  task automatic test_basic;
    logic [W-1:0] v[3] = '{F1, F2, F3};
    bus.start = 1; bus.num_err = 3;
    tick;
    bus.start = 0; bus.num_err = 0;
    for (int i = 0; i < 3; i++) begin
      bus.err_valid = 1; bus.err_in = v[i];
      #1;
      vecs++; if (bus.err_ready !== 1'b1) begin errs++; $display("FAIL basic_ready[%0d] got %h exp 1", i, bus.err_ready); end
      vecs++; if (bus.acc_en !== (i != 0)) begin errs++; $display("FAIL basic_acc_en[%0d] got %h exp %h", i, bus.acc_en, i != 0); end
      vecs++; if (bus.acc_input !== v[i]) begin errs++; $display("FAIL basic_acc_input[%0d] got %h exp %h", i, bus.acc_input, v[i]); end
      tick;
    end
    bus.err_valid = 0;
    vecs++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid got %h exp 0", bus.sum_valid); end
    tick;
    vecs++; if (bus.sum_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %h exp 1", bus.sum_valid); end
    vecs++; if (bus.sum_out !== F6) begin errs++; $display("FAIL basic_sum got %h exp %h", bus.sum_out, F6); end
    bus.sum_ready = 1;
    tick;
    bus.sum_ready = 0;
    vecs++; if (bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin errs++; $display("FAIL basic_idle got busy %h valid %h exp 0 0", bus.busy, bus.sum_valid); end
  endtask
  task automatic test_gap;
    logic [W-1:0] v[3] = '{F1, F2, F3};
    bus.start = 1; bus.num_err = 3;
    tick;
    bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2)
        for (int g = 0; g < 4; g++) begin
          bus.err_valid = 0; bus.err_in = F6;
          #1;
          vecs++; if (bus.acc_input !== '0 || bus.acc_en !== 1'b1) begin errs++; $display("FAIL gap_stall[%0d] got input %h en %h exp 0 1", g, bus.acc_input, bus.acc_en); end
          tick;
        end
      bus.err_valid = 1; bus.err_in = v[i];
      tick;
    end
    bus.err_valid = 0;
    tick;
    vecs++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== F6) begin errs++; $display("FAIL gap_sum got valid %h sum %h exp 1 %h", bus.sum_valid, bus.sum_out, F6); end
    bus.sum_ready = 1;
    tick;
    bus.sum_ready = 0;
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] v[2] = '{F3, F1};
    for (int i = 0; i < 2; i++) begin
      vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_idle[%0d] got %h exp 0", i, bus.busy); end
      bus.start = 1; bus.num_err = 1;
      tick;
      bus.start = 0; bus.err_valid = 1; bus.err_in = v[i];
      tick;
      bus.err_valid = 0;
      tick;
      vecs++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== v[i]) begin errs++; $display("FAIL b2b_sum[%0d] got valid %h sum %h exp 1 %h", i, bus.sum_valid, bus.sum_out, v[i]); end
      bus.sum_ready = 1;
      tick;
      bus.sum_ready = 0;
    end
  endtask
  task automatic test_zero;
    bus.start = 1; bus.num_err = 0;
    tick;
    bus.start = 0;
    vecs++; if (bus.err_ready !== 1'b0 || bus.sum_valid !== 1'b0 || bus.busy !== 1'b1) begin errs++; $display("FAIL zero_wait got ready %h valid %h busy %h exp 0 0 1", bus.err_ready, bus.sum_valid, bus.busy); end
    tick;
    vecs++; if (bus.sum_valid !== 1'b1 || bus.err_ready !== 1'b0) begin errs++; $display("FAIL zero_valid got valid %h ready %h exp 1 0", bus.sum_valid, bus.err_ready); end
    vecs++; if (bus.sum_out !== '0) begin errs++; $display("FAIL zero_sum got %h exp 0", bus.sum_out); end
    bus.sum_ready = 1;
    tick;
    bus.sum_ready = 0;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL zero_idle got %h exp 0", bus.busy); end
  endtask
  task automatic test_hold;
    bus.start = 1; bus.num_err = 1;
    tick;
    bus.start = 0; bus.err_valid = 1; bus.err_in = F2;
    tick;
    bus.err_valid = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      vecs++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== F2) begin errs++; $display("FAIL hold[%0d] got valid %h sum %h exp 1 %h", i, bus.sum_valid, bus.sum_out, F2); end
      bus.start = i == 2; bus.num_err = 2;
      tick;
    end
    bus.start = 0;
    bus.sum_ready = 1;
    tick;
    bus.sum_ready = 0;
    vecs++; if (bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin errs++; $display("FAIL hold_release got busy %h valid %h exp 0 0", bus.busy, bus.sum_valid); end
    tick;
    vecs++; if (bus.busy !== 1'b0 || bus.err_ready !== 1'b0) begin errs++; $display("FAIL hold_start_ignored got busy %h ready %h exp 0 0", bus.busy, bus.err_ready); end
  endtask
  task automatic test_reset_mid;
    bus.start = 1; bus.num_err = 3;
    tick;
    bus.start = 0; bus.err_valid = 1; bus.err_in = F1;
    tick;
    bus.err_in = F2;
    tick;
    bus.err_in = F3;
    #2;
    reset_n = 0;
    #1;
    vecs++; if (bus.err_ready !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL mid_rst_state got ready %h busy %h exp 0 0", bus.err_ready, bus.busy); end
    vecs++; if (bus.acc_input !== '0 || bus.acc_en !== 1'b0) begin errs++; $display("FAIL mid_rst_acc got input %h en %h exp 0 0", bus.acc_input, bus.acc_en); end
    vecs++; if (bus.sum_out !== '0 || bus.sum_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_sum got sum %h valid %h exp 0 0", bus.sum_out, bus.sum_valid); end
    bus.err_valid = 0;
    tick;
    reset_n = 1;
    tick;
    bus.start = 1; bus.num_err = 1;
    tick;
    bus.start = 0; bus.err_valid = 1; bus.err_in = F2;
    tick;
    bus.err_valid = 0;
    tick;
    vecs++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== F2) begin errs++; $display("FAIL mid_rst_burst got valid %h sum %h exp 1 %h", bus.sum_valid, bus.sum_out, F2); end
    bus.sum_ready = 1;
    tick;
    bus.sum_ready = 0;
  endtask
  task automatic test_random;
    int n, k, sum, v, d, guard;
    logic vld;
    logic [W-1:0] f;
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(0, 12);
      sum = 0; k = 0; guard = 0;
      bus.start = 1; bus.num_err = CW'(n);
      tick;
      bus.start = 0; bus.num_err = CW'($urandom);
      while (k < n && guard < 200) begin
        vld = $urandom_range(0, 3) != 0;
        v = $urandom_range(1, 16);
        f = int2f(v);
        bus.err_valid = vld;
        bus.err_in = vld ? f : W'($urandom);
        #1;
        vecs++; if (bus.err_ready !== 1'b1 || bus.acc_input !== (vld ? f : '0) || bus.acc_en !== (k != 0)) begin
          errs++; $display("FAIL rnd_feed[%0d.%0d] got ready %h input %h en %h exp 1 %h %h", b, k, bus.err_ready, bus.acc_input, bus.acc_en, vld ? f : '0, k != 0);
        end
        tick;
        guard++;
        if (vld) begin sum += v; k++; end
      end
      bus.err_valid = 0;
      vecs++; if (bus.sum_valid !== 1'b0 || bus.busy !== 1'b1) begin errs++; $display("FAIL rnd_wait[%0d] got valid %h busy %h exp 0 1", b, bus.sum_valid, bus.busy); end
      tick;
      d = $urandom_range(0, 3);
      for (int j = 0; j < d; j++) tick;
      vecs++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== int2f(sum)) begin errs++; $display("FAIL rnd_sum[%0d] got valid %h sum %h exp 1 %h", b, bus.sum_valid, bus.sum_out, int2f(sum)); end
      bus.sum_ready = 1;
      tick;
      bus.sum_ready = 0;
      vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rnd_idle[%0d] got %h exp 0", b, bus.busy); end
    end
  endtask
  initial begin
    bus.start = 0; bus.num_err = '0; bus.err_in = '0; bus.err_valid = 0; bus.sum_ready = 0;
    test_reset;
    test_basic;
    test_gap;
    test_back_to_back;
    test_zero;
    test_hold;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
